// File: rtl/rca_slice_seq_if.sv
// rca_slice_seq_if -- start/done handshake bundle for the sequential
// slice adder.
//
// Signals:
//   start     master -> slave  request; only looked at while busy = 0
//   a, b      master -> slave  operands, captured on the accepting edge
//   c_in      master -> slave  carry-in, captured on the accepting edge
//   busy      slave  -> master an add is in progress
//   done      slave  -> master one-cycle completion pulse
//   sum       slave  -> master registered result, held until next completion
//   c_out     slave  -> master registered carry out of the MSB
//   overflow  slave  -> master registered two's-complement overflow
interface rca_slice_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in,
        output busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/rca_slice_seq.sv
// rca_slice_seq -- WIDTH-bit adder built by reusing one 4-bit ripple-carry
// slice (rca4) over WIDTH/4 consecutive clock cycles.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset; clears all state and outputs
//   bus   rca_slice_seq_if.slave: start/a/b/c_in in, busy/done/sum/c_out/
//         overflow out (all outputs registered)
//
// An accepted add takes NSLICE edges; the result registers only change on
// the completion edge or on reset.

// 4-bit ripple-carry slice.
module rca4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        c_out = c[4];
    end
endmodule

module rca_slice_seq #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    rca_slice_seq_if.slave  bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = $clog2(NSLICE + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             a_msb;
    logic             b_msb;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;

    logic [3:0]       slice_sum;
    logic             slice_co;
    logic [WIDTH-1:0] work_next;
    logic             last_slice;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic signed_ovf(input logic sa, input logic sb,
                                        input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    rca4 u_slice (
        .a     (a_sh[3:0]),
        .b     (b_sh[3:0]),
        .c_in  (carry),
        .s     (slice_sum),
        .c_out (slice_co)
    );

    // Each new sum nibble enters at the top, so after NSLICE shifts the
    // first nibble computed has walked down to bits [3:0].
    assign work_next  = (work >> 4) | (WIDTH'(slice_sum) << (WIDTH - 4));
    assign last_slice = (cnt == CNT_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            work    <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        carry  <= bus.c_in;
                        cnt    <= '0;
                        work   <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    work  <= work_next;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (last_slice) begin
                        sum_q   <= work_next;
                        c_out_q <= slice_co;
                        ovf_q   <= signed_ovf(a_msb, b_msb, work_next[WIDTH-1]);
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.c_out    = c_out_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_rca_slice_seq.sv
// tb_rca_slice_seq -- directed bench for rca_slice_seq with a cycle-level
// reference model (plain 33-bit addition plus a latency countdown).
module tb_rca_slice_seq;
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rca_slice_seq_if #(.WIDTH(WIDTH)) bus ();

    rca_slice_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: result = a + b + c_in as a 33-bit number, visible
    // NSLICE edges after acceptance; requests are ignored while counting.
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_sum  = '0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [32:0] p_full;
    logic        p_ovf;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_busy = 0; m_done = 0;
            m_sum = '0; m_cout = 0; m_ovf = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sum  = p_full[31:0];
                    m_cout = p_full[32];
                    m_ovf  = p_ovf;
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                p_full = {1'b0, bus.a} + {1'b0, bus.b} + {32'd0, bus.c_in};
                p_ovf  = (bus.a[31] == bus.b[31]) && (p_full[31] != bus.a[31]);
                m_left = NSLICE;
            end
            m_busy = (m_left > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",     {63'd0, bus.busy},     {63'd0, m_busy});
            chk("done",     {63'd0, bus.done},     {63'd0, m_done});
            chk("sum",      {32'd0, bus.sum},      {32'd0, m_sum});
            chk("c_out",    {63'd0, bus.c_out},    {63'd0, m_cout});
            chk("overflow", {63'd0, bus.overflow}, {63'd0, m_ovf});
        end
    end

    // Issue one add, optionally disturbing start/operands during RUN, and
    // check the literal result plus latency and busy length.
    task automatic run_add(input string name, input logic [31:0] a,
                           input logic [31:0] b, input logic ci,
                           input logic [31:0] e_sum, input logic e_cout,
                           input logic e_ovf, input bit poke);
        int k;
        int busy_n;
        int extra;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.c_in = ci;
        busy_n = 0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            k = i;
            bus.start = (poke && (i == 2 || i == 5)) ? 1'b1 : 1'b0;
            if (poke) begin
                bus.a = $urandom; bus.b = $urandom; bus.c_in = 1'($urandom);
            end
            if (bus.done) break;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, 64'(k), 64'(NSLICE + 1));
        chk({name, "_busy_len"}, 64'(busy_n), 64'(NSLICE));
        chk({name, "_sum"}, {32'd0, bus.sum}, {32'd0, e_sum});
        chk({name, "_c_out"}, {63'd0, bus.c_out}, {63'd0, e_cout});
        chk({name, "_ovf"}, {63'd0, bus.overflow}, {63'd0, e_ovf});
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        chk({name, "_single_done"}, 64'(extra), 64'd0);
    endtask

    initial begin
        int dones;
        int first_t;
        int last_t;
        int cyc;

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;

        // Reset then idle.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", {63'd0, bus.busy}, 64'd0);
            chk("idle_sum",  {32'd0, bus.sum},  64'd0);
        end

        run_add("ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        run_add("mixed",   32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'hACF1_3569, 1'b0, 1'b0, 1'b1);
        run_add("ovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_add("ovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);

        // Reset during RUN: rst seen at edge T+4.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h1; bus.c_in = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_done", {63'd0, bus.done}, 64'd0);
        chk("abort_sum",  {32'd0, bus.sum},  64'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_done", {63'd0, bus.done}, 64'd0);
        end
        run_add("after_abort", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high and operands changing every cycle.
        dones = 0; first_t = 0; last_t = 0; cyc = 0;
        bus.start = 1'b1;
        while (dones < 1000 && cyc < 1000 * (NSLICE + 1) + 40) begin
            bus.a = $urandom; bus.b = $urandom; bus.c_in = 1'($urandom);
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (dones == 0) first_t = cyc;
                last_t = cyc;
                dones++;
            end
        end
        bus.start = 1'b0;
        chk("b2b_count",  64'(dones), 64'd1000);
        chk("b2b_period", 64'(last_t - first_t), 64'(999 * (NSLICE + 1)));
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
